derotator_afc_ctrl: RTL
=======================

# derotator_afc_ctrl

Automatic frequency control (AFC) sequencer that owns the `freq_word` input of the derotator. It acquires a coarse frequency estimate and slews `freq_word` to it at a bounded rate per symbol. It then closes a first-order fine loop on symbol-rate phase-error samples and reports lock. It sits between the coarse estimator / fine phase detector and the derotator, in the `clk` domain of the demod datapath.

## Interface
Parameters:
- `PHASE_WIDTH`, 32: width of `freq_word` and `coarse_freq` (two's complement, cycles/sample × 2^PHASE_WIDTH).
- `ERR_WIDTH`, 16: width of `fine_err`.
- `STEP_MAX`, 1048576: maximum `freq_word` change per symbol in SLEW. Must be >0.
- `KI_SHIFT`, 8: right shift applied to `fine_err` to form the loop increment.
- `LOCK_THR`, 512: lock threshold on |`fine_err`|.
- `LOCK_CNT`, 64: consecutive in-threshold errors required to assert lock.
- `UNLOCK_CNT`, 16: consecutive out-of-threshold errors (while locked) required to declare loss of lock.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: run the controller.
- `sym_valid` in 1: symbol strobe, aligned with derotator `sym_valid_out`.
- `coarse_valid` in 1: `coarse_freq` valid, single-cycle qualifier.
- `coarse_freq` in PHASE_WIDTH, signed: coarse target frequency word.
- `fine_valid` in 1: `fine_err` valid, one per symbol.
- `fine_err` in ERR_WIDTH, signed: phase-detector error.
- `freq_word` out PHASE_WIDTH, signed: registered frequency word to the derotator.
- `coarse_ack` out 1: one-cycle pulse when a coarse estimate is accepted.
- `locked` out 1: loop locked.
- `state` out 2: IDLE=0, ACQ=1, SLEW=2, TRACK=3.

## Operation
- **States:**
  - IDLE: waits for `enable`=1, then goes to ACQ.
  - ACQ: on `coarse_valid`, latches `coarse_freq` into `target`, pulses `coarse_ack`, and goes to SLEW.
  - SLEW: on each `sym_valid`, computes `diff = target - freq_word` in PHASE_WIDTH+1 bits.
    - If |diff| ≤ STEP_MAX: `freq_word <= target` and go to TRACK.
    - Otherwise: `freq_word <= freq_word ± STEP_MAX`, with the sign of `diff`.
  - TRACK: on each `fine_valid`, `freq_word <= sat(freq_word + (sext(fine_err) >>> KI_SHIFT))`.
    - The shift is arithmetic (floor).
    - Saturation is to [-2^(PW-1), 2^(PW-1)-1]. No wrap.
- **Lock:**
  - In TRACK, `lock_cnt` increments on `fine_valid` with |`fine_err`| ≤ LOCK_THR and clears on any error above LOCK_THR.
  - `locked` sets when `lock_cnt` reaches LOCK_CNT. `lock_cnt` then saturates.
- **Unlock:**
  - While `locked`=1, `unlock_cnt` counts consecutive `fine_valid` with |`fine_err`| > LOCK_THR and clears on any in-threshold error.
  - When `unlock_cnt` reaches UNLOCK_CNT: clear `locked`, clear both counters, go to ACQ. `freq_word` is held.
- `|fine_err|` for the most negative value is treated as 2^(ERR_WIDTH-1).
- `coarse_valid` outside ACQ:
  - In SLEW, or in TRACK with `locked`=0: the new target is accepted, `coarse_ack` pulses, and the state becomes SLEW. In TRACK this also clears the counters.
  - In TRACK with `locked`=1, or in IDLE: ignored, and no `coarse_ack`.
- `fine_valid` outside TRACK is ignored. `sym_valid` outside SLEW is ignored.
- `enable`=0 in any state: next state is IDLE, `locked` and both counters clear, and `freq_word` holds its value.
- Simultaneous `coarse_valid` and `fine_valid` in TRACK with `locked`=0: coarse wins, and the fine update is dropped.
- Simultaneous `enable` deassert and any valid: `enable` wins.

## Timing
- All outputs are registered.
- Reset values: `freq_word`=0, `coarse_ack`=0, `locked`=0, `state`=IDLE. `target` and the counters are 0.
- `rst` mid-operation returns everything to reset values on the next edge.
- Latencies:
  - ACQ: `coarse_valid` at cycle N gives `coarse_ack` and `state`=SLEW at N+1.
  - SLEW/TRACK: a qualifying `sym_valid` or `fine_valid` at cycle N gives the new `freq_word` at N+1.
  - `locked` rises at the cycle after the LOCK_CNT-th qualifying error.
  - IDLE→ACQ takes one cycle after `enable` rises.
- Throughput: one update per cycle is supported. Back-to-back `sym_valid` is legal.

## Test plan
- **Reset/idle:** assert `rst` for 3 cycles with `enable`=0 → `freq_word`=0, `state`=0, `locked`=0, no `coarse_ack`.
- **Slew:** `enable`, then `coarse_freq`=3,500,000 with STEP_MAX=1,048,576 and `sym_valid` every cycle.
  - Required: `coarse_ack` pulses once.
  - `freq_word` steps 1,048,576 → 2,097,152 → 3,145,728 → 3,500,000, then `state`=3.
- **Negative slew:** `coarse_freq`=-2,097,152 → two steps of -1,048,576, then TRACK on the second.
- **Fine loop/saturation:**
  - In TRACK, `fine_err`=-1 (KI_SHIFT=8) → `freq_word` decrements by 1 per `fine_valid`.
  - With `freq_word`=0x7FFFFF00 and `fine_err`=32767 repeated → `freq_word` saturates at 0x7FFFFFFF.
- **Lock/unlock:**
  - 64 errors of ±100 → `locked`=1 the cycle after the 64th.
  - Then 15 errors of 2000, 1 of 0, then 16 errors of 2000 → `locked`=0 and `state`=1 after the final one; `freq_word` unchanged.
- **Priority:** in TRACK with `locked`=0, drive `coarse_valid` and `fine_valid` together → fine update dropped and `state`=2.
  - Then drop `enable` mid-SLEW → `state`=0 next cycle and `freq_word` held.

Source files
------------

// File: rtl/derotator_afc_ctrl.sv
// derotator_afc_ctrl: AFC sequencer owning the derotator frequency word.
// Acquires a coarse estimate, slews freq_word toward it at a bounded rate
// per symbol, then runs a first-order fine loop with lock/unlock detection.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | controller disabled, freq_word held
// ACQ   | waiting for a coarse estimate
// SLEW  | stepping freq_word toward target, one step per symbol
// TRACK | fine loop closed on phase-error samples, lock detection live
module derotator_afc_ctrl #(
  parameter int PHASE_WIDTH = 32,
  parameter int ERR_WIDTH   = 16,
  parameter int STEP_MAX    = 1048576,
  parameter int KI_SHIFT    = 8,
  parameter int LOCK_THR    = 512,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_CNT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sym_valid,
  input  logic                   coarse_valid,
  input  logic [PHASE_WIDTH-1:0] coarse_freq,
  input  logic                   fine_valid,
  input  logic [ERR_WIDTH-1:0]   fine_err,
  output logic [PHASE_WIDTH-1:0] freq_word,
  output logic                   coarse_ack,
  output logic                   locked,
  output logic [1:0]             state
);

  localparam int PW  = PHASE_WIDTH;
  localparam int EW  = ERR_WIDTH;
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int UCW = $clog2(UNLOCK_CNT + 1);

  localparam logic [PW:0]    STEP_MAG  = (PW+1)'(STEP_MAX);
  localparam logic [PW-1:0]  STEP_WORD = PW'(STEP_MAX);
  localparam logic [EW:0]    THR_MAG   = (EW+1)'(LOCK_THR);
  localparam logic [LCW-1:0] LOCK_TC   = LCW'(LOCK_CNT);
  localparam logic [UCW-1:0] UNLOCK_TC = UCW'(UNLOCK_CNT);
  localparam logic [PW-1:0]  FW_MAX    = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0]  FW_MIN    = {1'b1, {(PW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_SLEW  = 2'd2,
    S_TRACK = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [PW-1:0]   freq_q, freq_n;
  logic [PW-1:0]   target_q, target_n;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_n;
  logic [UCW-1:0]  unlock_cnt_q, unlock_cnt_n;
  logic            locked_q, locked_n;
  logic            ack_q, ack_n;

  // Slew distance; one extra bit so target - freq_word never wraps.
  logic [PW:0] diff;
  logic [PW:0] diff_mag;
  assign diff     = {target_q[PW-1], target_q} - {freq_q[PW-1], freq_q};
  assign diff_mag = diff[PW] ? (-diff) : diff;

  // Loop increment: sign-extended error, arithmetic (floor) shift.
  logic signed [PW:0] err_ext;
  logic signed [PW:0] err_step;
  logic        [PW:0] fine_sum;
  logic [PW-1:0]      fine_sat;
  assign err_ext  = {{(PW+1-EW){fine_err[EW-1]}}, fine_err};
  assign err_step = err_ext >>> KI_SHIFT;
  assign fine_sum = {freq_q[PW-1], freq_q} + err_step;
  assign fine_sat = (fine_sum[PW] != fine_sum[PW-1]) ?
                    (fine_sum[PW] ? FW_MIN : FW_MAX) : fine_sum[PW-1:0];

  // |fine_err| with the most negative code mapping to 2^(EW-1).
  logic [EW:0] err_mag;
  logic        in_thr;
  assign err_mag = fine_err[EW-1] ? (-{1'b1, fine_err}) : {1'b0, fine_err};
  assign in_thr  = (err_mag <= THR_MAG);

  logic [LCW-1:0] lock_inc;
  logic [UCW-1:0] unlock_inc;
  assign lock_inc   = (lock_cnt_q == LOCK_TC) ? lock_cnt_q : lock_cnt_q + 1'b1;
  assign unlock_inc = unlock_cnt_q + 1'b1;

  // Next-state and datapath decisions; enable dominates every valid.
  always_comb begin
    state_n      = state_q;
    freq_n       = freq_q;
    target_n     = target_q;
    lock_cnt_n   = lock_cnt_q;
    unlock_cnt_n = unlock_cnt_q;
    locked_n     = locked_q;
    ack_n        = 1'b0;

    if (!enable) begin
      state_n      = S_IDLE;
      locked_n     = 1'b0;
      lock_cnt_n   = '0;
      unlock_cnt_n = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_n = S_ACQ;
        end

        S_ACQ: begin
          if (coarse_valid) begin
            target_n = coarse_freq;
            ack_n    = 1'b1;
            state_n  = S_SLEW;
          end
        end

        S_SLEW: begin
          // A fresh estimate retargets the slew; that cycle's step is skipped.
          if (coarse_valid) begin
            target_n = coarse_freq;
            ack_n    = 1'b1;
          end else if (sym_valid) begin
            if (diff_mag <= STEP_MAG) begin
              freq_n  = target_q;
              state_n = S_TRACK;
            end else if (diff[PW]) begin
              freq_n = freq_q - STEP_WORD;
            end else begin
              freq_n = freq_q + STEP_WORD;
            end
          end
        end

        S_TRACK: begin
          if (coarse_valid && !locked_q) begin
            target_n     = coarse_freq;
            ack_n        = 1'b1;
            lock_cnt_n   = '0;
            unlock_cnt_n = '0;
            state_n      = S_SLEW;
          end else if (fine_valid) begin
            if (locked_q && !in_thr && (unlock_inc == UNLOCK_TC)) begin
              // Loss of lock: freq_word is kept as the starting point for re-acquisition.
              locked_n     = 1'b0;
              lock_cnt_n   = '0;
              unlock_cnt_n = '0;
              state_n      = S_ACQ;
            end else begin
              freq_n = fine_sat;
              if (in_thr) begin
                lock_cnt_n   = lock_inc;
                unlock_cnt_n = '0;
                if (lock_inc == LOCK_TC) begin
                  locked_n = 1'b1;
                end
              end else begin
                lock_cnt_n = '0;
                if (locked_q) begin
                  unlock_cnt_n = unlock_inc;
                end
              end
            end
          end
        end

        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      freq_q       <= '0;
      target_q     <= '0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
      locked_q     <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      freq_q       <= freq_n;
      target_q     <= target_n;
      lock_cnt_q   <= lock_cnt_n;
      unlock_cnt_q <= unlock_cnt_n;
      locked_q     <= locked_n;
      ack_q        <= ack_n;
    end
  end

  assign freq_word  = freq_q;
  assign coarse_ack = ack_q;
  assign locked     = locked_q;
  assign state      = state_q;

endmodule
